riscv_fetch_unit: RTL and testbench

//  Decoupled, parametrised instruction-fetch stage for the pipelined core; replaces the bare PC register.
//  - Owns the PC and issues requests to a synchronous 1-cycle-latency instruction memory.
//  - Buffers returned words in a DEPTH-entry queue.
//  - Presents {pc, insn} to decode over a valid/ready handshake.
//  - Execute redirects (taken branch/jump) flush the queue and any in-flight response.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/riscv_fetch_unit.sv | 130 +++++++++++++
 tb/tb_riscv_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice: widths, reset vector,
// the JAL opcode and J-type immediate extraction.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [6:0]  OPC_JAL          = 7'b110_1111;

  // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} scattered over insn[31:12].
  function automatic logic signed [20:0] j_imm(input logic [31:0] insn);
    return $signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0});
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, insn, pred_taken} entries.
// Extra pointer bit distinguishes full from empty; head is read combinationally.
module fetch_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [31:0]              push_insn,
  input  logic                     push_pred,
  output logic [XLEN-1:0]          head_pc,
  output logic [31:0]              head_insn,
  output logic                     head_pred,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     insn_mem [DEPTH];
  logic            pred_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= push_pc;
      insn_mem[wr_ptr[AW-1:0]] <= push_insn;
      pred_mem[wr_ptr[AW-1:0]] <= push_pred;
    end
  end

  assign count     = wr_ptr - rd_ptr;
  assign head_pc   = pc_mem[rd_ptr[AW-1:0]];
  assign head_insn = insn_mem[rd_ptr[AW-1:0]];
  assign head_pred = pred_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: PC, epoch-tagged 1-cycle imem request, queue to decode.
// Optional static JAL prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module riscv_fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT),
  parameter int              DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_insn,
  output logic            out_pred_taken
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_next;
  logic            epoch;
  logic            epoch_flip;
  logic            vld_p1;
  logic [XLEN-1:0] tag_pc_p1;
  logic            tag_epoch_p1;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic            jal_taken;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_insn;
  logic            head_pred;

  // p0: issue. Queued entries plus the one in flight may never exceed DEPTH,
  // so every response is guaranteed a free slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clock) begin
    if (issue) begin
      tag_pc_p1    <= fetch_pc;
      tag_epoch_p1 <= epoch;
    end
  end

  // p1: response. Words from an older epoch, or arriving with a redirect, are discarded.
  assign push = vld_p1 && (tag_epoch_p1 == epoch) && !redirect_valid && !reset;

`ifdef FETCH_JAL_PREDICT_EN
  logic signed [XLEN-1:0] jal_off;
  logic [XLEN-1:0]        jal_target;

  assign jal_off    = XLEN'(j_imm(imem_data));
  assign jal_target = tag_pc_p1 + $unsigned(jal_off);
  assign jal_taken  = push && (imem_data[6:0] == OPC_JAL);
`else
  assign jal_taken  = 1'b0;
`endif

  always_comb begin
    pc_next    = fetch_pc;
    epoch_flip = 1'b0;
    if (redirect_valid) begin
      pc_next    = redirect_pc & ~XLEN'(3);
      epoch_flip = 1'b1;
    end
`ifdef FETCH_JAL_PREDICT_EN
    else if (jal_taken) begin
      // Flipping the epoch kills the sequential word issued alongside the JAL response.
      pc_next    = jal_target;
      epoch_flip = 1'b1;
    end
`endif
    else if (issue) begin
      pc_next = fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      fetch_pc <= pc_next;
      epoch    <= epoch ^ epoch_flip;
      vld_p1   <= issue;
    end
  end

  // p2: queue to decode; a redirect clears it and overrides any pop.
  assign head_valid = !reset && (count != '0);
  assign pop        = head_valid && out_ready && !redirect_valid;

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_pc   (tag_pc_p1),
    .push_insn (imem_data),
    .push_pred (jal_taken),
    .head_pc   (head_pc),
    .head_insn (head_insn),
    .head_pred (head_pred),
    .count     (count)
  );

  assign out_valid      = head_valid;
  assign out_pc         = head_valid ? head_pc   : '0;
  assign out_insn       = head_valid ? head_insn : '0;
  assign out_pred_taken = head_valid && head_pred;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: program-order stream model plus directed literal checks.
`timescale 1ns/1ps
module tb_riscv_fetch_unit;

  localparam logic [31:0] RPC      = 32'h0100_0000;
  localparam logic [31:0] JAL_PC   = 32'h0100_0008;
  localparam logic [31:0] JAL_INSN = 32'h0400_006F;  // jal x0, +0x40
`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic        out_pred_taken;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_insn       (out_insn),
    .out_pred_taken (out_pred_taken)
  );

  always #5 clock = ~clock;

  // Program image: one JAL, every other word an opcode-0x13 word unique to its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == JAL_PC) return JAL_INSN;
    return {a[26:2], 7'h13};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    if (PRED && pc == JAL_PC) return pc + 32'h40;
    return pc + 32'h4;
  endfunction

  // Instruction memory: word appears the cycle after the request, junk otherwise.
  logic [31:0] last_addr = '0;
  logic        last_req  = 1'b0;
  always @(posedge clock) begin
    last_req  <= imem_req;
    last_addr <= imem_addr;
  end
  assign imem_data = last_req ? mem_word(last_addr) : 32'hBAD0_0001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Stream model: every accepted head must be the next PC in program order.
  logic [31:0] exp_pc  = RPC;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_pc = '0;
  always @(negedge clock) begin
    if (imem_req) req_cnt++;
    if (hold_prev && !reset) begin
      chk("head_hold_valid", 32'(out_valid), 32'd1);
      chk("head_hold_pc", out_pc, hold_pc);
    end
    hold_prev = 1'b0;
    if (reset) begin
      exp_pc = RPC;
    end else if (redirect_valid) begin
      exp_pc = redirect_pc & ~32'h3;
    end else begin
      if (out_valid) begin
        chk("stream_pc", out_pc, exp_pc);
        chk("stream_insn", out_insn, mem_word(exp_pc));
        chk("stream_pred", 32'(out_pred_taken), 32'(PRED && exp_pc == JAL_PC));
        if (out_ready) exp_pc = next_pc(exp_pc);
        else begin
          hold_prev = 1'b1;
          hold_pc   = out_pc;
        end
      end else begin
        chk("idle_zero", out_pc | out_insn | 32'(out_pred_taken), 32'd0);
      end
      if (imem_req) chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
    end
  end

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_pred", 32'(out_pred_taken), 32'd0);

    // Streaming from reset release
    reset = 1'b0; out_ready = 1'b1; #1;
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", imem_addr, RPC);
    step(); chk("c1_valid", 32'(out_valid), 32'd0);
    step(); chk("c2_valid", 32'(out_valid), 32'd1); chk("c2_pc", out_pc, RPC);
    step(); chk("c3_pc", out_pc, RPC + 32'h4);
    step(); chk("c4_pc", out_pc, JAL_PC); chk("c4_insn", out_insn, JAL_INSN);
    chk("c4_pred", 32'(out_pred_taken), 32'(PRED));
    step(); chk("c5_valid", 32'(out_valid), PRED ? 32'd0 : 32'd1);
    chk("c5_pc", out_pc, PRED ? 32'd0 : RPC + 32'hC);
    step(); chk("c6_pc", out_pc, PRED ? RPC + 32'h48 : RPC + 32'h10);
    repeat (6) step();

    // Stall from reset: queue fills, requests stop, head held
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b0; req_cnt = 0;
    repeat (10) step();
    chk("stall_reqs", 32'(req_cnt), PRED ? 32'd5 : 32'd4);
    chk("stall_req_low", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_head_pc", out_pc, RPC);

    // Redirect with a full queue
    redirect_to(32'h0100_0102); #1;
    chk("rdf_n1_valid", 32'(out_valid), 32'd0);
    chk("rdf_n1_req", 32'(imem_req), 32'd1);
    chk("rdf_n1_addr", imem_addr, 32'h0100_0100);
    step(); chk("rdf_n2_valid", 32'(out_valid), 32'd0);
    step(); chk("rdf_n3_valid", 32'(out_valid), 32'd1);
    chk("rdf_n3_pc", out_pc, 32'h0100_0100);
    chk("rdf_n3_insn", out_insn, mem_word(32'h0100_0100));

    // Redirect while a response and a pop coincide
    out_ready = 1'b1;
    repeat (8) step();
    redirect_to(32'h0100_0200); #1;
    chk("rds_n1_valid", 32'(out_valid), 32'd0);
    step(); step(); chk("rds_n3_pc", out_pc, 32'h0100_0200);

    // Back-to-back redirects: the last one wins
    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0300; step();
    redirect_to(32'h0100_0400); #1;
    chk("rdb_n1_valid", 32'(out_valid), 32'd0);
    step(); step(); chk("rdb_n3_pc", out_pc, 32'h0100_0400);

    // Reset with 3 queued and 1 in flight
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b0;
    repeat (4) step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1; step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    reset = 1'b0; out_ready = 1'b1; #1;
    chk("restart_addr", imem_addr, RPC);
    chk("restart_req", 32'(imem_req), 32'd1);
    step(); step(); chk("restart_pc", out_pc, RPC);

    // Address wrap-around
    repeat (4) step();
    redirect_to(32'hFFFF_FFF8);
    repeat (8) step();

    // Irregular ready pattern with redirects back into the JAL region
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 3 != 2);
      if (i == 20 || i == 40 || i == 41) begin
        redirect_valid = 1'b1;
        redirect_pc    = (i == 41) ? 32'h0100_0001 : 32'h0100_0004;
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
